// File: rtl/common_pkg.sv
// Shared bus widths plus the target-side FSM state type and the doorbell offset helper.
package common_pkg;

    localparam int unsigned CPU_ADDR_WIDTH = 16;
    localparam int unsigned DATA_WIDTH     = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS
    } target_state_t;

    // The doorbell always occupies the last byte of the register window.
    function automatic int unsigned doorbell_offset(input int unsigned reg_addr_width);
        return (1 << reg_addr_width) - 1;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Registered rising/falling edge detector for a signal synchronous to clock_i.
module edge_detect #(
    parameter logic INITIAL_DATA_I = 1'b0
) (
    input  logic clock_i,
    input  logic reset_n_i,
    input  logic data_i,
    output logic pe_o,
    output logic ne_o
);

    logic prev;

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            prev <= INITIAL_DATA_I;
            pe_o <= 1'b0;
            ne_o <= 1'b0;
        end else begin
            prev <= data_i;
            pe_o <= data_i & ~prev;
            ne_o <= ~data_i & prev;
        end
    end

endmodule

// File: rtl/cpu_bus_target.sv
// 65C02 bus responder: byte register window with optional RDY wait states and a doorbell IRQ.
module cpu_bus_target
    import common_pkg::*;
#(
    parameter logic [CPU_ADDR_WIDTH-1:0] BASE_ADDR      = 16'hEF00,
    parameter int unsigned               REG_ADDR_WIDTH = 4,
    parameter int unsigned               WAIT_CYCLES    = 0
) (
    input  logic                      sys_clock_i,
    input  logic                      reset_n_i,
    input  logic                      cpu_clock_i,
    input  logic [CPU_ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0]     data_i,
    input  logic                      we_n_i,
    output logic [DATA_WIDTH-1:0]     data_o,
    output logic                      data_oe_o,
    output logic                      ready_o,
    output logic                      irq_n_o,
    output logic                      hit_o
);

    localparam int unsigned DEPTH = 1 << REG_ADDR_WIDTH;
    localparam logic [REG_ADDR_WIDTH-1:0] DOORBELL =
        REG_ADDR_WIDTH'(doorbell_offset(REG_ADDR_WIDTH));

    logic                      pe;
    logic                      ne;
    target_state_t             state;
    logic [REG_ADDR_WIDTH-1:0] offset;
    logic                      rw;
    logic [3:0]                wait_cnt;
    logic [DATA_WIDTH-1:0]     regs [DEPTH];

    logic                      hit;
    logic [REG_ADDR_WIDTH-1:0] addr_off;
    logic [3:0]                cnt_eff;
    logic                      need_wait;

    edge_detect #(
        .INITIAL_DATA_I(1'b0)
    ) u_phi2_edge (
        .clock_i  (sys_clock_i),
        .reset_n_i(reset_n_i),
        .data_i   (cpu_clock_i),
        .pe_o     (pe),
        .ne_o     (ne)
    );

    // A repeated cycle keeps its accumulated wait count; any other access starts over.
    always_comb begin
        hit       = addr_i[CPU_ADDR_WIDTH-1:REG_ADDR_WIDTH] ==
                    BASE_ADDR[CPU_ADDR_WIDTH-1:REG_ADDR_WIDTH];
        addr_off  = addr_i[REG_ADDR_WIDTH-1:0];
        cnt_eff   = ((addr_off == offset) && (we_n_i == rw)) ? wait_cnt : '0;
        need_wait = 32'(cnt_eff) < WAIT_CYCLES;
    end

    always_ff @(posedge sys_clock_i) begin
        if (!reset_n_i) begin
            state     <= ST_IDLE;
            offset    <= '0;
            rw        <= 1'b0;
            wait_cnt  <= '0;
            data_o    <= '0;
            data_oe_o <= 1'b0;
            ready_o   <= 1'b1;
            irq_n_o   <= 1'b1;
            hit_o     <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            hit_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Clearing here gives read data one cycle of hold past ne.
                    data_oe_o <= 1'b0;
                    ready_o   <= 1'b1;
                    if (pe) begin
                        if (hit) begin
                            offset <= addr_off;
                            rw     <= we_n_i;
                            if (need_wait) begin
                                state    <= ST_WAIT;
                                ready_o  <= 1'b0;
                                wait_cnt <= cnt_eff;
                            end else begin
                                state <= ST_ACCESS;
                                if (we_n_i) begin
                                    data_oe_o <= 1'b1;
                                    data_o    <= (addr_off == DOORBELL) ?
                                                 {{(DATA_WIDTH-1){1'b0}}, ~irq_n_o} :
                                                 regs[addr_off];
                                end
                            end
                        end else begin
                            wait_cnt <= '0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (ne) begin
                        wait_cnt <= wait_cnt + 4'd1;
                        ready_o  <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (ne) begin
                        if (rw) begin
                            if (offset == DOORBELL) begin
                                irq_n_o <= 1'b1;
                            end
                        end else begin
                            regs[offset] <= data_i;
                            if (offset == DOORBELL) begin
                                irq_n_o <= ~|data_i;
                            end
                        end
                        hit_o    <= 1'b1;
                        wait_cnt <= '0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
